// File: rtl/fetch_stage_if.sv
// Fetch stage bus: instruction-memory port plus decode-side signals.
// master = fetch stage, slave = memory/decode environment.
interface fetch_stage_if;
  logic        npc_control;
  logic [31:0] jump_target_PC;
  logic [1:0]  wait_signal;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic        inst_valid;

  modport master (
    input  npc_control,
    input  jump_target_PC,
    input  wait_signal,
    input  imem_rdata,
    output imem_rd_en,
    output imem_addr,
    output PC,
    output instruction,
    output inst_valid
  );

  modport slave (
    output npc_control,
    output jump_target_PC,
    output wait_signal,
    output imem_rdata,
    input  imem_rd_en,
    input  imem_addr,
    input  PC,
    input  instruction,
    input  inst_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC generation, 1-cycle imem reads,
// 2-entry return queue and IF/ID output register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  logic [31:0] fetch_pc;
  logic [31:0] inflight_pc;
  logic [31:0] tgt;
  logic        inflight;
  logic        stall;
  logic        redir;
  logic        issue;
  logic [1:0]  count;
  logic [2:0]  occ;
  logic        head;
  logic        tail;
  logic        push;
  logic        pop;
  logic        bypass;
  logic        out_valid;
  if_id_t      q [2];
  if_id_t      resp;
  if_id_t      out;

  assign stall = |bus.wait_signal;
  assign redir = bus.npc_control & ~stall;
  assign tgt   = {bus.jump_target_PC[31:2], 2'b00};

  // Queued plus in-flight words never exceed queue depth.
  assign occ   = {1'b0, count} + {2'b00, inflight};
  assign issue = rst_n & (redir | (occ < 3'd2));

  assign bus.imem_rd_en = issue;
  assign bus.imem_addr  = (rst_n & redir) ? tgt : fetch_pc;

  assign resp   = {inflight_pc, bus.imem_rdata};
  assign pop    = ~redir & ~stall & (count != 2'd0);
  assign push   = inflight & ~redir & (stall | (count != 2'd0));
  assign bypass = ~redir & ~stall & (count == 2'd0) & inflight;

  assign bus.PC          = out.pc;
  assign bus.instruction = out.inst;
  assign bus.inst_valid  = out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= bus.imem_addr + 32'd4;
        inflight_pc <= bus.imem_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) q[tail] <= resp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      head      <= 1'b0;
      tail      <= 1'b0;
      out       <= '{pc: 32'd0, inst: NOP_INST};
      out_valid <= 1'b0;
    end else begin
      if (redir) begin
        count <= 2'd0;
        head  <= 1'b0;
        tail  <= 1'b0;
      end else begin
        count <= count + {1'b0, push} - {1'b0, pop};
        head  <= head ^ pop;
        tail  <= tail ^ push;
      end
      unique case (1'b1)
        redir: begin
          out.inst  <= NOP_INST;
          out_valid <= 1'b0;
        end
        stall: begin
        end
        pop: begin
          out       <= q[head];
          out_valid <= 1'b1;
        end
        bypass: begin
          out       <= resp;
          out_valid <= 1'b1;
        end
        default: begin
          out.inst  <= NOP_INST;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against an imem model
// whose word at address a holds the value a.
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.imem_rdata <= bus.imem_addr;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic out_is(input string tag,
                        input logic [31:0] pc,
                        input logic [31:0] inst,
                        input logic v);
    chk({tag, "_pc"}, bus.PC, pc);
    chk({tag, "_inst"}, bus.instruction, inst);
    chk({tag, "_v"}, 32'(bus.inst_valid), 32'(v));
  endtask

  always @(negedge clk)
    if (rst_n)
      chk("q_bound", 32'(dut.count <= 2'd2), 32'd1);

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.npc_control = 1'b0;
    bus.jump_target_PC = 32'd0;
    bus.wait_signal = 2'b00;
    repeat (2) nxt;
    out_is("rst", 32'h0, 32'h13, 1'b0);
    chk("rst_rd", 32'(bus.imem_rd_en), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);

    // Reset release and streaming
    rst_n = 1'b1;
    #1;
    chk("first_rd", 32'(bus.imem_rd_en), 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0);
    nxt;
    chk("e1_v", 32'(bus.inst_valid), 32'd0);
    chk("e1_addr", bus.imem_addr, 32'h4);
    nxt;
    out_is("s0", 32'h0, 32'h0, 1'b1);
    chk("s0_rd", 32'(bus.imem_rd_en), 32'd1);
    nxt;
    out_is("s4", 32'h4, 32'h4, 1'b1);
    chk("s4_rd", 32'(bus.imem_rd_en), 32'd1);
    nxt;
    out_is("s8", 32'h8, 32'h8, 1'b1);

    // Four stalled cycles at PC=8
    bus.wait_signal = 2'b01;
    #1;
    chk("st1_rd", 32'(bus.imem_rd_en), 32'd1);
    nxt;
    out_is("st1", 32'h8, 32'h8, 1'b1);
    chk("st2_rd", 32'(bus.imem_rd_en), 32'd0);
    nxt;
    out_is("st2", 32'h8, 32'h8, 1'b1);
    chk("st_count", 32'(dut.count), 32'd2);
    chk("st3_rd", 32'(bus.imem_rd_en), 32'd0);
    nxt;
    out_is("st3", 32'h8, 32'h8, 1'b1);
    nxt;
    out_is("st4", 32'h8, 32'h8, 1'b1);
    bus.wait_signal = 2'b00;
    #1;
    chk("rel_rd", 32'(bus.imem_rd_en), 32'd0);
    nxt;
    out_is("r0", 32'hC, 32'hC, 1'b1);
    nxt;
    out_is("r1", 32'h10, 32'h10, 1'b1);
    nxt;
    out_is("r2", 32'h14, 32'h14, 1'b1);
    nxt;
    out_is("r3", 32'h18, 32'h18, 1'b1);

    // Redirect to 0x100
    bus.npc_control = 1'b1;
    bus.jump_target_PC = 32'h100;
    #1;
    chk("jmp_addr", bus.imem_addr, 32'h100);
    chk("jmp_rd", 32'(bus.imem_rd_en), 32'd1);
    nxt;
    bus.npc_control = 1'b0;
    out_is("jmp_bub", 32'h18, 32'h13, 1'b0);
    nxt;
    out_is("jmp_t", 32'h100, 32'h100, 1'b1);
    nxt;
    out_is("jmp_t4", 32'h104, 32'h104, 1'b1);

    // Redirect held off by a stall
    bus.wait_signal = 2'b10;
    bus.npc_control = 1'b1;
    bus.jump_target_PC = 32'h300;
    #1;
    chk("sj_addr0", bus.imem_addr, 32'h10C);
    chk("sj_rd0", 32'(bus.imem_rd_en), 32'd1);
    nxt;
    out_is("sj_hold", 32'h104, 32'h104, 1'b1);
    chk("sj_rd1", 32'(bus.imem_rd_en), 32'd0);
    chk("sj_addr1", bus.imem_addr, 32'h110);
    bus.wait_signal = 2'b00;
    #1;
    chk("sj_addr2", bus.imem_addr, 32'h300);
    chk("sj_rd2", 32'(bus.imem_rd_en), 32'd1);
    nxt;
    bus.npc_control = 1'b0;
    out_is("sj_bub", 32'h104, 32'h13, 1'b0);
    nxt;
    out_is("sj_t", 32'h300, 32'h300, 1'b1);

    // Misaligned target is word-aligned
    bus.npc_control = 1'b1;
    bus.jump_target_PC = 32'h203;
    #1;
    chk("al_addr", bus.imem_addr, 32'h200);
    nxt;
    bus.npc_control = 1'b0;
    chk("al_bub", 32'(bus.inst_valid), 32'd0);
    nxt;
    out_is("al_t", 32'h200, 32'h200, 1'b1);

    // Fetch PC wraps past 0xFFFF_FFFC
    bus.npc_control = 1'b1;
    bus.jump_target_PC = 32'hFFFF_FFFC;
    #1;
    chk("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
    nxt;
    bus.npc_control = 1'b0;
    #1;
    chk("wr_next", bus.imem_addr, 32'h0);
    chk("wr_rd", 32'(bus.imem_rd_en), 32'd1);
    nxt;
    out_is("wr_t", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
    nxt;
    out_is("wr_0", 32'h0, 32'h0, 1'b1);

    // Asynchronous reset with a full queue
    bus.wait_signal = 2'b01;
    repeat (3) nxt;
    chk("rq_count", 32'(dut.count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    out_is("ar", 32'h0, 32'h13, 1'b0);
    chk("ar_rd", 32'(bus.imem_rd_en), 32'd0);
    chk("ar_addr", bus.imem_addr, 32'h0);
    chk("ar_count", 32'(dut.count), 32'd0);
    nxt;
    bus.wait_signal = 2'b00;
    rst_n = 1'b1;
    #1;
    chk("ar_rd1", 32'(bus.imem_rd_en), 32'd1);
    chk("ar_addr1", bus.imem_addr, 32'h0);
    nxt;
    chk("ar_e1_v", 32'(bus.inst_valid), 32'd0);
    nxt;
    out_is("ar_s0", 32'h0, 32'h0, 1'b1);
    nxt;
    out_is("ar_s4", 32'h4, 32'h4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
